// File: rtl/nand_chain_pkg.sv
// nand_chain_pkg
// Shared definitions for the NAND chain solver slice.
//   - solver_state_e : solver FSM state encoding
//   - W_DEFAULT      : default number of chain inputs
//   - bit-order constants naming the stage and input positions
package nand_chain_pkg;

    localparam int W_DEFAULT = 4;

    // Stage vector bit order: bit0 is the first NAND (e), then f, g, ...
    localparam int STAGE_E_BIT = 0;
    localparam int STAGE_F_BIT = 1;
    localparam int STAGE_G_BIT = 2;

    // Input vector bit order: bit0 = a, bit1 = b, bit2 = c, bit3 = d, ...
    localparam int INPUT_A_BIT = 0;
    localparam int INPUT_B_BIT = 1;
    localparam int INPUT_C_BIT = 2;
    localparam int INPUT_D_BIT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } solver_state_e;

endpackage

// File: rtl/nand_chain_eval.sv
// nand_chain_eval
// Purely combinational W-input cascaded NAND chain.
//   stage0 = ~(x0 & x1), stage k = ~(stage(k-1) & x(k+1))
// Ports:
//   x      in  W    chain inputs (bit0 = a)
//   stages out W-1  stage outputs (bit0 = first stage)
module nand_chain_eval
    import nand_chain_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W-1:0] x,
    output logic [W-2:0] stages
);

    // A scalar accumulator carries the ripple so the stage vector is never
    // read back inside the same block.
    always_comb begin
        logic acc;
        acc       = ~(x[0] & x[1]);
        stages    = '0;
        stages[0] = acc;
        for (int k = 1; k < W - 1; k++) begin
            acc       = ~(acc & x[k+1]);
            stages[k] = acc;
        end
    end

endmodule

// File: rtl/nand_chain_solver.sv
// nand_chain_solver
// Reverse solver for the cascaded NAND chain: enumerates every input vector
// in ascending order, one per clock, and streams each vector whose stage
// outputs match the requested pattern (under a care mask), then pulses a
// done indication with the number of solutions emitted.
//
// Build option:
//   NAND_SOLVER_FIRST_ONLY_EN  - when defined, stop after the first accepted
//                                solution (done_count is then 0 or 1).
//
// Ports:
//   clk         in   1    clock, rising edge
//   rst_n       in   1    asynchronous active-low reset
//   req_valid   in   1    new solve request
//   req_ready   out  1    high only in IDLE
//   req_target  in   W-1  required stage values
//   req_mask    in   W-1  1 = compare stage bit, 0 = don't care
//   sol_valid   out  1    solution present
//   sol_ready   in   1    consumer accepts solution
//   sol_inputs  out  W    matching input vector
//   sol_stages  out  W-1  stage vector produced by sol_inputs
//   done_valid  out  1    one-cycle pulse at end of scan
//   done_count  out  W+1  solutions emitted, valid with done_valid
//   busy        out  1    high in SCAN, EMIT and DONE
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request, req_ready high
// SCAN  | evaluating the chain on cnt, one candidate per cycle
// EMIT  | holding a solution on sol_* until sol_ready
// DONE  | one-cycle done pulse carrying the match count
module nand_chain_solver
    import nand_chain_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-2:0] req_target,
    input  logic [W-2:0] req_mask,
    output logic         sol_valid,
    input  logic         sol_ready,
    output logic [W-1:0] sol_inputs,
    output logic [W-2:0] sol_stages,
    output logic         done_valid,
    output logic [W:0]   done_count,
    output logic         busy
);

    solver_state_e state;
    logic [W-1:0]  cnt;
    logic [W:0]    match_cnt;
    logic [W-2:0]  target_r;
    logic [W-2:0]  mask_r;
    logic [W-2:0]  stages;
    logic          hit;
    logic          last;

    nand_chain_eval #(.W(W)) u_eval (
        .x      (cnt),
        .stages (stages)
    );

    assign hit  = (((stages ^ target_r) & mask_r) == '0);
    assign last = &cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            match_cnt  <= '0;
            target_r   <= '0;
            mask_r     <= '0;
            req_ready  <= 1'b1;
            sol_valid  <= 1'b0;
            sol_inputs <= '0;
            sol_stages <= '0;
            done_valid <= 1'b0;
            done_count <= '0;
            busy       <= 1'b0;
        end else begin
            done_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        target_r  <= req_target;
                        mask_r    <= req_mask;
                        cnt       <= '0;
                        match_cnt <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        sol_inputs <= cnt;
                        sol_stages <= stages;
                        sol_valid  <= 1'b1;
                        state      <= EMIT;
                    end else if (last) begin
                        done_valid <= 1'b1;
                        done_count <= match_cnt;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + W'(1);
                    end
                end
                EMIT: begin
                    if (sol_ready) begin
                        // done_count takes the incremented value directly
                        // since match_cnt itself updates on this same edge.
                        match_cnt <= match_cnt + (W+1)'(1);
                        sol_valid <= 1'b0;
`ifdef NAND_SOLVER_FIRST_ONLY_EN
                        done_valid <= 1'b1;
                        done_count <= match_cnt + (W+1)'(1);
                        state      <= DONE;
`else
                        if (last) begin
                            done_valid <= 1'b1;
                            done_count <= match_cnt + (W+1)'(1);
                            state      <= DONE;
                        end else begin
                            cnt   <= cnt + W'(1);
                            state <= SCAN;
                        end
`endif
                    end
                end
                DONE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_chain_solver.sv
module tb_nand_chain_solver;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [W-2:0] req_target;
    logic [W-2:0] req_mask;
    logic         sol_valid;
    logic         sol_ready;
    logic [W-1:0] sol_inputs;
    logic [W-2:0] sol_stages;
    logic         done_valid;
    logic [W:0]   done_count;
    logic         busy;

    nand_chain_solver #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .req_mask   (req_mask),
        .sol_valid  (sol_valid),
        .sol_ready  (sol_ready),
        .sol_inputs (sol_inputs),
        .sol_stages (sol_stages),
        .done_valid (done_valid),
        .done_count (done_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int sol_q[$];
    int done_q[$];
    int done_pulses = 0;

    // Reference chain for W=4: e = ~(a&b), f = ~(e&c), g = ~(f&d)
    function automatic int ref_stages(input int v);
        logic a, b, c, d, e, f, g;
        a = v[0]; b = v[1]; c = v[2]; d = v[3];
        e = ~(a & b);
        f = ~(e & c);
        g = ~(f & d);
        return int'({g, f, e});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        int e;
        if (rst_n) begin
            if (sol_valid && sol_ready) begin
                if (sol_q.size() == 0) begin
                    check("sol_unexpected", int'(sol_inputs), -1);
                end else begin
                    e = sol_q.pop_front();
                    check("sol_inputs", int'(sol_inputs), e);
                    check("sol_stages", int'(sol_stages), ref_stages(e));
                end
            end
            if (done_valid) begin
                done_pulses++;
                if (done_q.size() == 0) begin
                    check("done_unexpected", int'(done_count), -1);
                end else begin
                    e = done_q.pop_front();
                    check("done_count", int'(done_count), e);
                end
            end
        end
    end

    task automatic run_req(input logic [W-2:0] target, input logic [W-2:0] mask,
                           input int exp[$], input int stall_n, output int lat);
        int stalled;
        int first;
        first = (exp.size() > 0) ? exp[0] : -1;
`ifdef NAND_SOLVER_FIRST_ONLY_EN
        if (exp.size() > 0) begin
            sol_q.push_back(exp[0]);
            done_q.push_back(1);
        end else begin
            done_q.push_back(0);
        end
`else
        foreach (exp[i]) sol_q.push_back(exp[i]);
        done_q.push_back(exp.size());
`endif
        stalled   = 0;
        sol_ready = (stall_n == 0);
        @(negedge clk);
        check("req_ready_idle", int'(req_ready), 1);
        req_target = target;
        req_mask   = mask;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!done_valid && lat < 400) begin
            if (stall_n > 0 && !sol_ready && sol_valid) begin
                check("stall_inputs", int'(sol_inputs), first);
                stalled++;
                if (stalled == stall_n) begin
                    @(posedge clk);
                    #1 sol_ready = 1'b1;
                end
            end
            @(negedge clk);
            lat++;
        end
        if (!done_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: no done_valid within %0d cycles", lat);
        end
        @(negedge clk);
        check("done_one_cycle", int'(done_valid), 0);
        check("sol_queue_drained", sol_q.size(), 0);
        if (stall_n > 0) check("stall_cycles", stalled, stall_n);
        sol_ready = 1'b1;
    endtask

    initial begin
        int q[$];
        int lat;
        int pulses_before;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_target = '0;
        req_mask   = '0;
        sol_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready",  int'(req_ready), 1);
        check("rst_sol_valid",  int'(sol_valid), 0);
        check("rst_done_valid", int'(done_valid), 0);
        check("rst_busy",       int'(busy), 0);
        check("rst_done_count", int'(done_count), 0);
        check("rst_sol_inputs", int'(sol_inputs), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // g = 0 only
        q = {8, 9, 10, 11, 15};
        run_req(3'b000, 3'b100, q, 0, lat);

        // e = f = g = 1
        q = {0, 1, 2};
        run_req(3'b111, 3'b111, q, 0, lat);

        // e = 0, f = 0 is unreachable
        q = {};
        run_req(3'b000, 3'b011, q, 0, lat);
        check("latency_no_match", lat, 17);

        // mask = 0: every vector
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(i);
        run_req(3'b000, 3'b000, q, 0, lat);

        // g = 0 with first solution held off for 5 cycles
        q = {8, 9, 10, 11, 15};
        run_req(3'b000, 3'b100, q, 5, lat);

        // Reset mid-scan
        pulses_before = done_pulses;
        sol_ready  = 1'b1;
        @(negedge clk);
        req_target = 3'b000;
        req_mask   = 3'b011;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("scan_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", int'(req_ready), 1);
        check("abort_busy",      int'(busy), 0);
        check("abort_sol_valid", int'(sol_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_done", done_pulses, pulses_before);
        check("abort_idle_ready", int'(req_ready), 1);

        // Normal operation after the abort
        q = {0, 1, 2};
        run_req(3'b111, 3'b111, q, 0, lat);

        check("done_queue_drained", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
